prng_arbiter: RTL
=================

PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the generator (2..8).
REQ-002 Parameter DEFAULT_SEED, default 32'd12403709: LFSR value at reset and substitute for a zero seed.
REQ-003 Parameter WARMUP_CYCLES, default 4: LFSR steps taken after reset or seed load before any grant (1..255).
REQ-004 clk_i  input  1: the single clock; all state updates on its rising edge.
REQ-005 reset_ni  input  1: asynchronous, active-low reset.
REQ-006 req_i  input  NUM_REQ: per-requester request, held high until granted.
REQ-007 gnt_o  output  NUM_REQ: one-hot grant, a single-cycle pulse.
REQ-008 rnd_o  output  32: random word, valid only in a cycle where gnt_o is non-zero.
REQ-009 seed_we_i  input  1: single-cycle strobe that loads seed_i.
REQ-010 seed_i  input  32: new seed value.
REQ-011 busy_o  output  1: high while in WARMUP.
REQ-012 grant_cnt_o  output  16: total grants issued since reset, wrapping.

Function
REQ-013 The block SHALL contain one 32-bit LFSR, state S, which advances by one step as S_next = (S << 1) | (S[27]^S[23]^S[19]^S[18]^S[15]^S[11]^S[7]^S[4]^S[1]).
REQ-014 S SHALL change only on a WARMUP step, a grant, or a seed load; otherwise it holds.
REQ-015 The FSM SHALL have exactly two states: WARMUP and READY.
REQ-016 In WARMUP the LFSR SHALL step once per cycle while a counter runs from WARMUP_CYCLES down to 1; the step that consumes count 1 moves the FSM to READY on the same edge.
REQ-017 In WARMUP, gnt_o SHALL be 0 regardless of req_i.
REQ-018 In READY with req_i != 0 and seed_we_i low, exactly one gnt_o bit SHALL be high in that same cycle (combinational grant, zero latency).
REQ-019 In a grant cycle, rnd_o SHALL equal the current S, and S SHALL advance one step at the following edge.
REQ-020 Arbitration SHALL be round-robin: the search starts at index ptr and wraps modulo NUM_REQ; ptr resets to 0.
REQ-021 After a grant to index k, ptr SHALL become (k+1) mod NUM_REQ.
REQ-022 At most one grant SHALL be issued per cycle; a requester held high SHALL be re-granted no sooner than after every other active requester has been served.
REQ-023 In READY with req_i == 0, the block SHALL produce no grant and S, ptr and grant_cnt_o SHALL hold.
REQ-024 When rnd_o is not valid it SHALL be driven 0.
REQ-025 On seed_we_i in any state, S SHALL load seed_i, or DEFAULT_SEED if seed_i == 0 (this avoids the all-zero lock-up).
REQ-026 A seed load SHALL also restart WARMUP with a full WARMUP_CYCLES count.
REQ-027 A seed load SHALL leave ptr and grant_cnt_o unchanged.
REQ-028 When seed_we_i coincides with pending requests in READY, the seed load SHALL win and no grant is issued that cycle.
REQ-029 When seed_we_i arrives during WARMUP, the countdown SHALL restart and the WARMUP step of that cycle is discarded.
REQ-030 grant_cnt_o SHALL increment by 1 on every grant and wrap from 16'hFFFF to 0.
REQ-031 busy_o SHALL be high exactly when the FSM is in WARMUP.

Reset
REQ-032 While reset_ni is low, independent of clk_i: S = DEFAULT_SEED, FSM = WARMUP, warm-up counter = WARMUP_CYCLES, ptr = 0, grant_cnt_o = 0, gnt_o = 0, rnd_o = 0, busy_o = 1.
REQ-033 Reset asserted mid-operation SHALL abort any warm-up or grant immediately, with no partial update surviving.
REQ-034 After reset_ni rises, WARMUP SHALL begin at the first clock edge.

Verification
REQ-035 Warm-up and sequence: seed_we_i with seed_i = 32'h1 (WARMUP_CYCLES = 4) -> busy_o high for 4 cycles, then rnd_o = 32'h15 on the first grant and 32'h2B, 32'h57, 32'hAE on the next three grants.
REQ-036 Zero seed: seed_i = 0 with seed_we_i -> S = 32'd12403709 and busy_o high for 4 cycles.
REQ-037 Round-robin: req_i = 4'b1111 held -> gnt_o sequence 0001, 0010, 0100, 1000, 0001; grant_cnt_o increments by 1 per cycle.
REQ-038 Collision: seed_we_i in the same cycle as req_i = 4'b0100 in READY -> gnt_o = 0, busy_o = 1 next cycle, and the grant is issued after warm-up with ptr preserved.
REQ-039 Reset mid-warm-up: drop reset_ni at warm-up step 2 -> all outputs at reset values asynchronously; after release, 4 warm-up cycles from DEFAULT_SEED.
REQ-040 Counter wrap: force 65536 grants -> grant_cnt_o returns to 0 with no change to grant behaviour.

Source files
------------

// File: rtl/prng_arbiter.sv
// prng_arbiter: a round-robin arbiter that hands out words from one shared
// 32-bit LFSR. Each grant is combinational, in the same cycle as the request,
// and carries the current LFSR word on rnd_o. After reset or a seed load the
// LFSR steps through a warm-up period before any grant is issued.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_WARMUP  | LFSR steps every cycle while the counter runs down; no grants
// ST_READY   | LFSR holds; it steps once for each grant issued

module prng_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter logic [31:0] DEFAULT_SEED  = 32'd12403709,
  parameter int          WARMUP_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [31:0]        rnd_o,
  input  logic               seed_we_i,
  input  logic [31:0]        seed_i,
  output logic               busy_o,
  output logic [15:0]        grant_cnt_o
);

  localparam int         PTR_W     = $clog2(NUM_REQ);
  localparam logic [7:0] WARM_INIT = 8'(WARMUP_CYCLES);

  typedef enum logic {ST_WARMUP, ST_READY} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        grant_cnt_q, grant_cnt_d;

  logic               hit;
  logic [PTR_W-1:0]   hit_idx;
  logic [PTR_W-1:0]   cand;

  // One LFSR step. The shift pushes bit 31 out, and the feedback bit enters at bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[27] ^ s[23] ^ s[19] ^ s[18] ^ s[15] ^ s[11] ^ s[7] ^ s[4] ^ s[1];
    return (s << 1) | {31'd0, fb};
  endfunction

  // Find the first active requester, searching from ptr and wrapping modulo NUM_REQ.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!hit && req_i[cand]) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
  end

  // Next state and outputs. A seed load overrides both the warm-up step and any grant.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    ptr_d       = ptr_q;
    grant_cnt_d = grant_cnt_q;
    gnt_o       = '0;
    rnd_o       = '0;

    if (seed_we_i) begin
      lfsr_d  = (seed_i == 32'd0) ? DEFAULT_SEED : seed_i;
      state_d = ST_WARMUP;
      cnt_d   = WARM_INIT;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          lfsr_d = lfsr_step(lfsr_q);
          if (cnt_q == 8'd1) begin
            state_d = ST_READY;
            cnt_d   = WARM_INIT;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_READY: begin
          if (hit) begin
            gnt_o[hit_idx] = 1'b1;
            rnd_o          = lfsr_q;
            lfsr_d         = lfsr_step(lfsr_q);
            ptr_d          = (hit_idx == PTR_W'(NUM_REQ - 1)) ? '0 : hit_idx + PTR_W'(1);
            grant_cnt_d    = grant_cnt_q + 16'd1;
          end
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  // State registers. The asynchronous reset discards any warm-up step or grant in progress.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_WARMUP;
      cnt_q       <= WARM_INIT;
      lfsr_q      <= DEFAULT_SEED;
      ptr_q       <= '0;
      grant_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      ptr_q       <= ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign busy_o      = (state_q == ST_WARMUP);
  assign grant_cnt_o = grant_cnt_q;

endmodule
